// File: rtl/ecp5pll_pkg.sv
// Shared definitions for the ECP5 PLL wrapper and its dynamic phase-shift controller.
// Frequencies are in kHz so the range checks stay in plain integer arithmetic.
package ecp5pll_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStepHi,
        StStepLo,
        StPause,
        StFinish
    } state_e;

    // One phasestep pulse moves an output by 1/8 of a VCO period.
    localparam int unsigned STEPS_PER_VCO = 8;

    localparam int unsigned PFD_MIN_KHZ = 3125;
    localparam int unsigned PFD_MAX_KHZ = 400000;
    localparam int unsigned VCO_MIN_KHZ = 400000;
    localparam int unsigned VCO_MAX_KHZ = 800000;

    // Fine steps per 360 degrees of an output with the given divider.
    function automatic int unsigned phase_steps(input int unsigned output_div);
        return STEPS_PER_VCO * output_div;
    endfunction

    function automatic bit pfd_in_range(input int unsigned pfd_khz);
        return (pfd_khz >= PFD_MIN_KHZ) && (pfd_khz <= PFD_MAX_KHZ);
    endfunction

    function automatic bit vco_in_range(input int unsigned vco_khz);
        return (vco_khz >= VCO_MIN_KHZ) && (vco_khz <= VCO_MAX_KHZ);
    endfunction

endpackage

// File: rtl/ecp5pll_lock_filter.sv
// PLL lock qualifier: two-flop synchroniser followed by a saturating counter; the gate
// opens only after LOCK_WAIT consecutive synchronised-high cycles.
module ecp5pll_lock_filter #(
    parameter int unsigned LOCK_WAIT = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic locked_i,
    output logic gate_o
);

    localparam int unsigned CW = (LOCK_WAIT > 0) ? $clog2(LOCK_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_VAL = CW'(LOCK_WAIT);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= locked_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != WAIT_VAL) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A single low sample closes the gate in the same cycle it is seen.
    assign gate_o = sync2_q && (cnt_q == WAIT_VAL);

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Dynamic phase-shift sequencer for the ECP5 PLL wrapper: accepts absolute per-channel
// phase targets and walks the output there along the shorter direction, pausing on lock loss.
module ecp5pll_phase_ctrl #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PHASE_W   = 10,
    parameter logic [CHANNELS*PHASE_W-1:0] CH_STEPS =
        {CHANNELS{PHASE_W'(ecp5pll_pkg::phase_steps(8))}},
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned LOCK_WAIT = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [1:0]                  req_ch_i,
    input  logic [PHASE_W-1:0]          req_phase_i,
    output logic                        req_err_o,
    input  logic                        pll_locked_i,
    output logic [1:0]                  phasesel_o,
    output logic                        phasedir_o,
    output logic                        phasestep_o,
    output logic                        phaseloadreg_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CHANNELS*PHASE_W-1:0] cur_phase_o
);

    import ecp5pll_pkg::*;

    localparam int unsigned TMAX =
        (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                                : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
    localparam int unsigned TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

    function automatic logic [PHASE_W-1:0] steps_of(input logic [1:0] ch);
        return CH_STEPS[32'(ch)*PHASE_W +: PHASE_W];
    endfunction

    state_e state_q, state_d;

    logic [TW-1:0]      timer_q, timer_d;
    logic [PHASE_W-1:0] count_q, count_d;
    logic [1:0]         sel_q, sel_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;
    logic               done_eq_q, done_eq_d;
    logic [PHASE_W-1:0] cur_q [CHANNELS];
    logic [PHASE_W-1:0] cur_d [CHANNELS];

    logic               lock_ok;
    logic               hs, ch_ok, rej, start;
    logic               tmr_zero, step_done;
    logic [1:0]         ch_idx;
    logic [PHASE_W-1:0] n_req, cur_req, diff, half, req_count;
    logic               req_dir;
    logic [PHASE_W-1:0] n_sel, cur_sel, step_phase;

    ecp5pll_lock_filter #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_filter (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .locked_i (pll_locked_i),
        .gate_o   (lock_ok)
    );

    // Request decode: validity and shortest-path direction/count
    assign hs      = req_valid_i && req_ready_o;
    assign ch_ok   = 32'(req_ch_i) < CHANNELS;
    assign ch_idx  = ch_ok ? req_ch_i : 2'd0;
    assign n_req   = steps_of(ch_idx);
    assign cur_req = cur_q[ch_idx];
    assign rej     = !ch_ok || (req_phase_i >= n_req);
    assign start   = hs && !rej && (diff != '0);

    always_comb begin
        // Both operands are below N, so adding N on borrow yields (target - cur) mod N.
        diff = req_phase_i - cur_req;
        if (req_phase_i < cur_req) begin
            diff = diff + n_req;
        end
        half = n_req >> 1;
        if (diff <= half) begin
            req_dir   = 1'b0;
            req_count = diff;
        end else begin
            req_dir   = 1'b1;
            req_count = n_req - diff;
        end
    end

    // Tracked phase of the channel being stepped, wrapped modulo its N
    assign n_sel     = steps_of(sel_q);
    assign cur_sel   = cur_q[sel_q];
    assign tmr_zero  = (timer_q == '0);
    assign step_done = (state_q == StStepLo) && tmr_zero;

    always_comb begin
        if (dir_q) begin
            step_phase = (cur_sel == '0) ? n_sel - 1'b1 : cur_sel - 1'b1;
        end else begin
            step_phase = (cur_sel == n_sel - 1'b1) ? '0 : cur_sel + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StSetup;
            end
            StSetup: begin
                if (tmr_zero) state_d = lock_ok ? StStepHi : StPause;
            end
            StStepHi: begin
                if (tmr_zero) state_d = StStepLo;
            end
            StStepLo: begin
                if (tmr_zero) begin
                    if (count_q == PHASE_W'(1)) begin
                        state_d = StFinish;
                    end else begin
                        state_d = lock_ok ? StStepHi : StPause;
                    end
                end
            end
            StPause: begin
                if (lock_ok) state_d = StSetup;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready_o = (state_q == StIdle) && lock_ok;
        busy_o      = (state_q != StIdle);
        phasestep_o = (state_q == StStepHi);
        done_o      = (state_q == StFinish) || done_eq_q;
    end

    // Datapath next state
    always_comb begin
        timer_d   = timer_q;
        count_d   = count_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        cur_d     = cur_q;
        err_d     = hs && rej;
        done_eq_d = hs && !rej && (diff == '0);

        if (state_d != state_q) begin
            case (state_d)
                StSetup:  timer_d = SETUP_LD;
                StStepHi: timer_d = PULSE_LD;
                StStepLo: timer_d = GAP_LD;
                default:  timer_d = '0;
            endcase
        end else if (!tmr_zero) begin
            timer_d = timer_q - 1'b1;
        end

        // sel/dir only load from IDLE, so they stay frozen for the whole sequence.
        if (start) begin
            sel_d   = ch_idx;
            dir_d   = req_dir;
            count_d = req_count;
        end

        if (step_done) begin
            count_d        = count_q - 1'b1;
            cur_d[sel_q]   = step_phase;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            timer_q   <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            done_eq_q <= 1'b0;
            cur_q     <= '{default: '0};
        end else begin
            timer_q   <= timer_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            done_eq_q <= done_eq_d;
            cur_q     <= cur_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cur
        assign cur_phase_o[c*PHASE_W +: PHASE_W] = cur_q[c];
    end

    assign req_err_o      = err_q;
    assign phasesel_o     = sel_q;
    assign phasedir_o     = dir_q;
    // Static phase load is not used by the wrapper.
    assign phaseloadreg_o = 1'b0;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Bench for ecp5pll_phase_ctrl: directed and random phase moves compared against a
// shortest-path model of each channel's phase, plus lock-loss and async-reset cases.
module tb_ecp5pll_phase_ctrl;

    localparam int CHANNELS  = 3;
    localparam int PHASE_W   = 10;
    localparam int SETUP_CYC = 2;
    localparam int PULSE_CYC = 4;
    localparam int GAP_CYC   = 4;
    localparam int LOCK_WAIT = 16;
    localparam logic [CHANNELS*PHASE_W-1:0] CH_STEPS = {10'd40, 10'd64, 10'd64};

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        req_valid;
    logic                        req_ready;
    logic [1:0]                  req_ch;
    logic [PHASE_W-1:0]          req_phase;
    logic                        req_err;
    logic                        pll_locked;
    logic [1:0]                  phasesel;
    logic                        phasedir;
    logic                        phasestep;
    logic                        phaseloadreg;
    logic                        busy;
    logic                        done;
    logic [CHANNELS*PHASE_W-1:0] cur_phase;

    int n_tab [CHANNELS] = '{64, 64, 40};
    int model [CHANNELS];
    int n_cmp = 0;
    int n_err = 0;

    int   rises = 0;
    int   hi_run = 0;
    int   lo_run = 0;
    bit   had_pulse = 0;
    bit   moved = 0;
    logic busy_prev = 1'b0;
    logic [1:0] sel_prev = 2'd0;
    logic dir_prev = 1'b0;

    always #5 clk = ~clk;

    ecp5pll_phase_ctrl #(
        .CHANNELS  (CHANNELS),
        .PHASE_W   (PHASE_W),
        .CH_STEPS  (CH_STEPS),
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_ch_i       (req_ch),
        .req_phase_i    (req_phase),
        .req_err_o      (req_err),
        .pll_locked_i   (pll_locked),
        .phasesel_o     (phasesel),
        .phasedir_o     (phasedir),
        .phasestep_o    (phasestep),
        .phaseloadreg_o (phaseloadreg),
        .busy_o         (busy),
        .done_o         (done),
        .cur_phase_o    (cur_phase)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cur_of(input int ch);
        return int'(cur_phase[ch*PHASE_W +: PHASE_W]);
    endfunction

    // Pulse shape and sel/dir stability watcher
    always @(negedge clk) begin
        if (!rstn) begin
            hi_run    = 0;
            lo_run    = 0;
            had_pulse = 0;
        end else begin
            if (phasestep) begin
                if (hi_run == 0) begin
                    rises++;
                    if (had_pulse) check("gap_width", int'(lo_run >= GAP_CYC), 1);
                end
                hi_run++;
                lo_run = 0;
            end else begin
                if (hi_run != 0) begin
                    check("pulse_width", hi_run, PULSE_CYC);
                    had_pulse = 1;
                end
                hi_run = 0;
                lo_run++;
            end
            if (!busy) had_pulse = 0;
            if (busy && busy_prev && (phasesel != sel_prev || phasedir != dir_prev)) moved = 1;
        end
        busy_prev = busy;
        sel_prev  = phasesel;
        dir_prev  = phasedir;
    end

    task automatic check_all_cur(input string tag);
        for (int c = 0; c < CHANNELS; c++) check({tag, "_cur"}, cur_of(c), model[c]);
    endtask

    task automatic wait_ready(input int bound, input string tag);
        int k = 0;
        while (!req_ready && k < bound) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, int'(req_ready), 1);
    endtask

    // Presents one request at a negedge; returns at the negedge one cycle after the handshake.
    task automatic issue(input int ch, input int tgt);
        req_ch    = 2'(ch);
        req_phase = 10'(tgt);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        moved = 0;
        @(negedge clk);
    endtask

    task automatic move(input int ch, input int tgt, input string tag);
        int n, d, cnt, dir, k, r0;
        bit rej;
        wait_ready(400, tag);
        r0  = rises;
        rej = (ch >= CHANNELS) || (tgt >= n_tab[ch]);
        issue(ch, tgt);
        check({tag, "_err"}, int'(req_err), int'(rej));
        if (rej) begin
            check({tag, "_done"}, int'(done), 0);
            repeat (6) @(negedge clk);
            check({tag, "_steps"}, rises - r0, 0);
            check_all_cur(tag);
            return;
        end
        n = n_tab[ch];
        d = (tgt - model[ch] + n) % n;
        if (d <= n / 2) begin
            cnt = d;
            dir = 0;
        end else begin
            cnt = n - d;
            dir = 1;
        end
        if (cnt == 0) begin
            check({tag, "_done"}, int'(done), 1);
            check({tag, "_busy"}, int'(busy), 0);
        end else begin
            check({tag, "_busy"}, int'(busy), 1);
            check({tag, "_sel"}, int'(phasesel), ch);
            check({tag, "_dir"}, int'(phasedir), dir);
            k = 1;
            while (!done && k < 3000) begin
                @(negedge clk);
                k++;
            end
            check({tag, "_latency"}, k, SETUP_CYC + cnt * (PULSE_CYC + GAP_CYC) + 1);
        end
        model[ch] = tgt;
        check({tag, "_steps"}, rises - r0, cnt);
        check({tag, "_phase"}, cur_of(ch), tgt);
        check({tag, "_seldir_held"}, int'(moved), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r0, r1, tgt, ch, sel;
        req_valid  = 1'b0;
        req_ch     = 2'd0;
        req_phase  = '0;
        pll_locked = 1'b1;
        rstn       = 1'b0;
        for (int c = 0; c < CHANNELS; c++) model[c] = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(req_err), 0);
        check("rst_step", int'(phasestep), 0);
        check("rst_sel", int'(phasesel), 0);
        check("rst_dir", int'(phasedir), 0);
        check("rst_load", int'(phaseloadreg), 0);
        check("rst_cur", int'(cur_phase), 0);
        #2 rstn = 1'b1;
        @(negedge clk);

        move(1, 5, "fwd5");
        move(1, 60, "rev_wrap");
        move(0, 32, "tie");
        move(0, 32, "zero");
        move(3, 1, "rej_ch");
        move(1, 64, "rej_ph");
        check("loadreg_low", int'(phaseloadreg), 0);

        // Lock drop in the 3rd pulse of a 6-step forward move on ch2 (N=40)
        wait_ready(400, "drop");
        r0 = rises;
        issue(2, 6);
        k = 0;
        while (rises < r0 + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("drop_third_pulse", rises - r0, 3);
        pll_locked = 1'b0;
        repeat (12) @(negedge clk);
        check("drop_paused_step", int'(phasestep), 0);
        check("drop_paused_busy", int'(busy), 1);
        check("drop_paused_ready", int'(req_ready), 0);
        check("drop_counted", cur_of(2), 3);
        r1 = rises;
        repeat (20) @(negedge clk);
        check("drop_no_steps", rises - r1, 0);
        pll_locked = 1'b1;
        k = 0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drop_done", int'(done), 1);
        check("drop_total_steps", rises - r0, 6);
        check("drop_final", cur_of(2), 6);
        check("drop_seldir_held", int'(moved), 0);
        model[2] = 6;
        @(negedge clk);

        // Random requests, including repeats of the current phase and out-of-range targets
        for (int i = 0; i < 25; i++) begin
            ch = int'($urandom_range(0, 3));
            if (ch < CHANNELS) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0) tgt = model[ch];
                else if (sel == 1) tgt = n_tab[ch] + int'($urandom_range(0, 5));
                else tgt = int'($urandom_range(0, n_tab[ch] - 1));
            end else begin
                tgt = int'($urandom_range(0, 63));
            end
            move(ch, tgt, "rand");
        end
        check_all_cur("rand_end");

        // Asynchronous reset while phasestep is high
        wait_ready(400, "rst_mid");
        r0  = rises;
        tgt = (model[0] + 20) % 64;
        issue(0, tgt);
        k = 0;
        while (rises == r0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_pulse", int'(phasestep), 1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_step", int'(phasestep), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_ready", int'(req_ready), 0);
        check("rst_mid_cur", int'(cur_phase), 0);
        for (int c = 0; c < CHANNELS; c++) model[c] = 0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        move(1, 7, "post_rst");
        move(2, 35, "post_rst_rev");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
